// File: rtl/agc_threshold_trigger.sv
// Threshold trigger on packed AGC samples with holdoff and a gated trigger-rate scaler.
// Define AGC_TRIG_PEAK_EN to also report the peak magnitude of each triggering cycle.
module agc_threshold_trigger #(
    parameter int unsigned NSAMP       = 8,
    parameter int unsigned NBITS       = 5,
    parameter int unsigned HOLDOFF_W   = 8,
    parameter int unsigned SCALER_W    = 16,
    parameter int unsigned GATE_CYCLES = 125000
) (
    input  logic                       aclk,
    input  logic                       reset_i,
    input  logic [NSAMP*NBITS-1:0]     dat_i,
    input  logic                       enable_i,
    input  logic [NBITS-1:0]           threshold_i,
    input  logic [HOLDOFF_W-1:0]       holdoff_i,
    output logic                       trig_o,
    output logic [$clog2(NSAMP)-1:0]   trig_idx_o,
    output logic [NBITS-1:0]           peak_o,
    output logic [SCALER_W-1:0]        scaler_o,
    output logic                       scaler_valid_o
);

    localparam int unsigned IDX_W  = $clog2(NSAMP);
    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_HOLDOFF = 1'b1;

    localparam logic [HOLDOFF_W-1:0] HCNT_ONE  = HOLDOFF_W'(1);
    localparam logic [SCALER_W-1:0]  TCNT_ONE  = SCALER_W'(1);
    localparam logic [SCALER_W-1:0]  TCNT_MAX  = {SCALER_W{1'b1}};
    localparam logic [GATE_W-1:0]    GATE_ONE  = GATE_W'(1);
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    // Input register
    logic [NSAMP*NBITS-1:0] dat_q;

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            dat_q <= '0;
        end else begin
            dat_q <= dat_i;
        end
    end

    // Compare stage: -2^(NBITS-1) maps to 2^(NBITS-1), which still fits unsigned NBITS
    logic [NBITS-1:0] mag [NSAMP];
    logic [NSAMP-1:0] hit_d;
    logic [NSAMP-1:0] hit_q;

    always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
            if (dat_q[NBITS*k + NBITS - 1]) begin
                mag[k] = {NBITS{1'b0}} - dat_q[NBITS*k +: NBITS];
            end else begin
                mag[k] = dat_q[NBITS*k +: NBITS];
            end
            hit_d[k] = mag[k] > threshold_i;
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

`ifdef AGC_TRIG_PEAK_EN
    logic [NBITS-1:0] peak_d;
    logic [NBITS-1:0] peak_q;

    always_comb begin
        peak_d = '0;
        for (int k = 0; k < NSAMP; k++) begin
            if (mag[k] > peak_d) begin
                peak_d = mag[k];
            end
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end
`endif

    // Trigger FSM
    logic [0:0]           state_q, state_d;
    logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
    logic                 fire;
    logic [IDX_W-1:0]     first_idx;

    always_comb begin
        first_idx = '0;
        for (int k = NSAMP - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                first_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && (|hit_q)) begin
                    fire = 1'b1;
                    if (holdoff_i != '0) begin
                        hcnt_d  = holdoff_i;
                        state_d = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                hcnt_d = hcnt_q - HCNT_ONE;
                if (hcnt_q == HCNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            trig_o     <= 1'b0;
            trig_idx_o <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            trig_o  <= fire;
            if (fire) begin
                trig_idx_o <= first_idx;
            end
        end
    end

`ifdef AGC_TRIG_PEAK_EN
    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            peak_o <= '0;
        end else if (fire) begin
            peak_o <= peak_q;
        end
    end
`else
    assign peak_o = '0;
`endif

    // Scaler: the trig_o pulse visible in the wrap cycle still belongs to the closing gate
    logic [GATE_W-1:0]   gcnt_q;
    logic [SCALER_W-1:0] tcnt_q;
    logic [SCALER_W-1:0] tcnt_inc;
    logic                gate_wrap;

    always_comb begin
        gate_wrap = gcnt_q == GATE_LAST;
        tcnt_inc  = tcnt_q;
        if (trig_o && (tcnt_q != TCNT_MAX)) begin
            tcnt_inc = tcnt_q + TCNT_ONE;
        end
    end

    always_ff @(posedge aclk or posedge reset_i) begin
        if (reset_i) begin
            gcnt_q         <= '0;
            tcnt_q         <= '0;
            scaler_o       <= '0;
            scaler_valid_o <= 1'b0;
        end else begin
            scaler_valid_o <= gate_wrap;
            if (gate_wrap) begin
                gcnt_q   <= '0;
                tcnt_q   <= '0;
                scaler_o <= tcnt_inc;
            end else begin
                gcnt_q <= gcnt_q + GATE_ONE;
                tcnt_q <= tcnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_agc_threshold_trigger.sv
// Bench for agc_threshold_trigger: directed table, multi-cycle sequences and a randomized run
// checked every cycle against an edge-indexed behavioural model.
module tb_agc_threshold_trigger;

    localparam int G = 16;
`ifdef AGC_TRIG_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        reset_i;
    logic [39:0] dat_i;
    logic        enable_i;
    logic [4:0]  threshold_i;
    logic [7:0]  holdoff_i;

    logic        trig0, trig1, v0, v1;
    logic [2:0]  idx0, idx1;
    logic [4:0]  peak0, peak1;
    logic [15:0] sc0;
    logic [2:0]  sc1;

    always #5 aclk = ~aclk;

    agc_threshold_trigger #(.GATE_CYCLES(G)) dut0 (
        .aclk(aclk), .reset_i(reset_i), .dat_i(dat_i), .enable_i(enable_i),
        .threshold_i(threshold_i), .holdoff_i(holdoff_i), .trig_o(trig0),
        .trig_idx_o(idx0), .peak_o(peak0), .scaler_o(sc0), .scaler_valid_o(v0)
    );

    agc_threshold_trigger #(.GATE_CYCLES(G), .SCALER_W(3)) dut1 (
        .aclk(aclk), .reset_i(reset_i), .dat_i(dat_i), .enable_i(enable_i),
        .threshold_i(threshold_i), .holdoff_i(holdoff_i), .trig_o(trig1),
        .trig_idx_o(idx1), .peak_o(peak1), .scaler_o(sc1), .scaler_valid_o(v1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] smp(input int k, input int v);
        logic [39:0] r = '0;
        r[5*k +: 5] = 5'(v);
        return r;
    endfunction

    // Behavioural model: everything indexed by edge number e since reset release
    int          e;
    logic [39:0] dh [4];
    int          th [4];
    bit          m_trig, m_valid;
    int          m_idx, m_peak, m_cnt0, m_cnt1, m_sc0, m_sc1, next_ok;
    int          any_hit, lo, mx, sv, mg;
    logic [39:0] d;

    initial begin
        forever begin
            @(posedge aclk or posedge reset_i);
            if (reset_i) begin
                e = 0; next_ok = 0;
                m_trig = 0; m_valid = 0; m_idx = 0; m_peak = 0;
                m_cnt0 = 0; m_cnt1 = 0; m_sc0 = 0; m_sc1 = 0;
                for (int i = 0; i < 4; i++) begin
                    dh[i] = '0;
                    th[i] = 0;
                end
            end else begin
                // Hit decision for this edge: data from edge e-2, threshold from edge e-1
                d = dh[(e + 2) % 4];
                any_hit = 0; lo = -1; mx = 0;
                for (int k = 0; k < 8; k++) begin
                    sv = $signed(d[5*k +: 5]);
                    mg = (sv < 0) ? -sv : sv;
                    if (mg > th[(e + 3) % 4]) begin
                        any_hit = 1;
                        if (lo < 0) lo = k;
                    end
                    if (mg > mx) mx = mg;
                end
                if (m_trig) begin
                    m_cnt0 = (m_cnt0 < 65535) ? m_cnt0 + 1 : m_cnt0;
                    m_cnt1 = (m_cnt1 < 7) ? m_cnt1 + 1 : m_cnt1;
                end
                m_valid = 0;
                if (e % G == G - 1) begin
                    m_sc0 = m_cnt0; m_sc1 = m_cnt1; m_valid = 1;
                    m_cnt0 = 0; m_cnt1 = 0;
                end
                m_trig = enable_i && (any_hit != 0) && (e >= next_ok);
                if (m_trig) begin
                    m_idx   = lo;
                    m_peak  = PEAK_EN ? mx : 0;
                    next_ok = e + int'(holdoff_i) + 1;
                end
                dh[e % 4] = dat_i;
                th[e % 4] = int'(threshold_i);
                e++;
            end
        end
    end

    bit mon_en = 0;
    initial begin
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                chk("mon.trig0", trig0, m_trig);
                chk("mon.idx0", idx0, m_idx);
                chk("mon.peak0", peak0, m_peak);
                chk("mon.scaler0", sc0, m_sc0);
                chk("mon.valid0", v0, m_valid);
                chk("mon.trig1", trig1, m_trig);
                chk("mon.idx1", idx1, m_idx);
                chk("mon.peak1", peak1, m_peak);
                chk("mon.scaler1", sc1, m_sc1);
                chk("mon.valid1", v1, m_valid);
            end
        end
    end

    task automatic wait_valid(input string name);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!v0 && t < 40);
        chk({name, ".valid"}, v0, 1);
    endtask

    task automatic wait_phase(input int ph);
        do begin
            @(posedge aclk);
            #1;
        end while ((e - 1) % G != ph);
    endtask

    typedef struct {
        logic [39:0] dat;
        logic [4:0]  thr;
        bit          trig;
        int          idx;
        int          peak;
    } vec_t;

    vec_t        tab [8];
    logic [39:0] pat;
    int          n, first, second;

    initial begin
        tab[0] = '{smp(3, -11), 5'd10, 1'b1, 3, 11};
        tab[1] = '{smp(3, 10), 5'd10, 1'b0, 0, 0};
        tab[2] = '{smp(0, -16) | smp(1, 3) | smp(2, 12), 5'd11, 1'b1, 0, 16};
        tab[3] = '{smp(7, 15) | smp(5, -1), 5'd14, 1'b1, 7, 15};
        tab[4] = '{40'd0, 5'd0, 1'b0, 0, 0};
        tab[5] = '{smp(2, -1), 5'd0, 1'b1, 2, 1};
        tab[6] = '{smp(4, -16), 5'd15, 1'b1, 4, 16};
        tab[7] = '{smp(1, 5) | smp(6, -9), 5'd4, 1'b1, 1, 9};
        pat = smp(2, 7) | smp(6, 7);

        reset_i = 1'b1; dat_i = '0; enable_i = 1'b1; threshold_i = 5'd10; holdoff_i = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset.trig", trig0, 0);
        chk("reset.idx", idx0, 0);
        chk("reset.peak", peak0, 0);
        chk("reset.scaler", sc0, 0);
        chk("reset.valid", v0, 0);
        chk("reset.scaler1", sc1, 0);
        reset_i = 1'b0;
        mon_en = 1;

        // Single-cycle pulses, latency exactly two cycles
        for (int i = 0; i < 8; i++) begin
            @(posedge aclk); #1;
            threshold_i = tab[i].thr;
            dat_i = tab[i].dat;
            @(posedge aclk); #1;
            dat_i = '0;
            @(posedge aclk);
            @(negedge aclk);
            chk($sformatf("tab%0d.early", i), trig0, 0);
            @(posedge aclk);
            @(negedge aclk);
            chk($sformatf("tab%0d.trig", i), trig0, tab[i].trig);
            if (tab[i].trig) begin
                chk($sformatf("tab%0d.idx", i), idx0, tab[i].idx);
                chk($sformatf("tab%0d.peak", i), peak0, PEAK_EN ? tab[i].peak : 0);
            end
            repeat (3) @(posedge aclk);
        end

        // Holdoff of 4 over a 10-cycle hit: triggers 5 cycles apart
        @(posedge aclk); #1;
        threshold_i = 5'd5; holdoff_i = 8'd4; dat_i = pat;
        n = 0; first = -100; second = -100;
        for (int i = 0; i < 24; i++) begin
            @(posedge aclk); #1;
            if (i == 9) dat_i = '0;
            @(negedge aclk);
            if (trig0) begin
                if (n == 0) first = i;
                else if (n == 1) second = i;
                n++;
                chk("hold.idx", idx0, 2);
            end
        end
        chk("hold.count", n, 2);
        chk("hold.lat", first, 2);
        chk("hold.gap", second - first, 5);
        holdoff_i = '0;

        // Back-to-back triggers, then with enable dropped for five compare cycles
        for (int pass = 0; pass < 2; pass++) begin
            n = 0;
            for (int j = 0; j < 30; j++) begin
                @(posedge aclk); #1;
                dat_i = (j < 20) ? pat : '0;
                enable_i = !(pass == 1 && j >= 7 && j <= 11);
                @(negedge aclk);
                if (trig0) n++;
            end
            enable_i = 1'b1;
            chk(pass ? "burst.gapped" : "burst.full", n, pass ? 15 : 20);
        end

        // Trigger every cycle for a whole gate; the 3-bit scaler saturates
        @(posedge aclk); #1;
        dat_i = pat;
        repeat (4) @(posedge aclk);
        wait_valid("gate.first");
        wait_valid("gate.full");
        chk("gate.scaler16", sc0, 16);
        chk("gate.scaler_sat", sc1, 7);
        @(posedge aclk); #1;
        dat_i = '0;
        repeat (24) @(posedge aclk);

        // Single trigger visible only in the wrap cycle
        wait_phase(11);
        dat_i = pat;
        @(posedge aclk); #1;
        dat_i = '0;
        wait_valid("wrap");
        chk("wrap.scaler", sc0, 1);
        chk("wrap.scaler1", sc1, 1);

        // Five triggers, the last opening a long holdoff, then reset mid-holdoff
        wait_phase(15);
        n = 0;
        for (int j = 0; j < 9; j++) begin
            dat_i = (j < 6) ? pat : '0;
            holdoff_i = (j >= 6) ? 8'd200 : 8'd0;
            @(posedge aclk); #1;
            @(negedge aclk);
            if (trig0) n++;
            @(posedge aclk); #1;
            j++;
            if (j < 9) begin
                dat_i = (j < 6) ? pat : '0;
                holdoff_i = (j >= 6) ? 8'd200 : 8'd0;
                @(negedge aclk);
                if (trig0) n++;
            end
        end
        chk("rst.pre_count", n, 5);
        reset_i = 1'b1;
        #1;
        chk("rst.trig", trig0, 0);
        chk("rst.idx", idx0, 0);
        chk("rst.peak", peak0, 0);
        chk("rst.scaler", sc0, 0);
        chk("rst.valid", v0, 0);
        chk("rst.scaler1", sc1, 0);
        dat_i = '0; holdoff_i = '0;
        @(negedge aclk);
        reset_i = 1'b0;
        @(posedge aclk); #1;
        dat_i = pat;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        dat_i = '0;
        wait_valid("rst.gate");
        chk("rst.gate_scaler", sc0, 2);

        // Randomized run against the model
        for (int i = 0; i < 800; i++) begin
            @(posedge aclk); #1;
            dat_i = ($urandom_range(0, 1) == 0) ? '0 : 40'({$urandom(), $urandom()});
            threshold_i = 5'($urandom_range(0, 17));
            holdoff_i = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 6)) : 8'd0;
            enable_i = ($urandom_range(0, 9) != 0);
        end
        repeat (2) @(negedge aclk);
        mon_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
